lcd_msg_arbiter: RTL and testbench
==================================

# lcd_msg_arbiter

Shares the single 16x2 character display among several independent message sources: game status, score, timer and alerts. Each requester offers a pair of 128-bit lines (16 ASCII characters each). The arbiter grants one requester at a time, round-robin, and holds the granted text on the display for a minimum dwell time. Its word_line1/word_line2 outputs drive the LCD refresh sequencer directly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 50_000_000, minimum in_CLK cycles a granted message stays on the outputs; 0 is treated as 1
- CNT_W, 26, hold counter width; must hold HOLD_CYCLES-1
- in_CLK  in  1  system clock
- in_RST_N  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held high until the matching ack
- req_line1  in  NUM_REQ*128  line-1 text; requester i occupies bits [i*128+127 : i*128]
- req_line2  in  NUM_REQ*128  line-2 text; same packing as req_line1
- req_ack  out  NUM_REQ  one-cycle pulse; text of requester i was latched
- word_line1  out  128  text shown on line 1 (MSB byte = leftmost character)
- word_line2  out  128  text shown on line 2
- owner  out  clog2(NUM_REQ)  index of the last granted requester
- busy  out  1  high while the hold interval runs
- update  out  1  one-cycle pulse in the cycle the word lines change

## Operation
- Reset values:
  - word_line1/2 = 16 ASCII spaces (128'h2020…20)
  - req_ack = 0, update = 0, busy = 0, owner = 0
  - RR pointer = NUM_REQ-1, so requester 0 wins first
  - state = IDLE, hold counter = 0
- State IDLE: when any req_valid bit is high, the winner is the first set bit searching upward from pointer+1 with wrap-around.
  - On the next clock edge: latch the winner's lines, pulse req_ack[winner] and update, set owner = pointer = winner.
  - Load the counter with HOLD_CYCLES-1 and go to HOLD.
- State HOLD: busy = 1; the counter decrements once per cycle.
  - At count 0 with any req_valid high: grant immediately (back-to-back) from the new pointer and reload the counter.
  - At count 0 with no request: go to IDLE.
- Requests arriving during HOLD wait; they are never dropped while req_valid stays high.
- A requester that deasserts req_valid before its ack is simply skipped.
- Only bits of req_valid sampled in the grant cycle matter. Requesters may change their line data at any time except the grant cycle.
- Sole requester: re-granted every HOLD_CYCLES cycles while req_valid stays high; the text is relatched each time.

## Timing
- Grant latency: req_valid high in cycle N with state IDLE means ack, update and the new word lines appear in cycle N+1.
- Consecutive updates are at least HOLD_CYCLES cycles apart; exactly HOLD_CYCLES when back-to-back.
- busy rises with the grant cycle and falls the cycle after count 0 when no request is pending.
- Reset asserted mid-HOLD: all outputs return to reset values asynchronously. The first grant occurs no earlier than the second edge after deassertion.

## Configuration
- LCD_ARB_PRIO_EN defined: requester 0 is an urgent alert source.
  - In HOLD, if req_valid[0] = 1 and owner ≠ 0, requester 0 is granted on the next edge and the counter reloads.
  - This preemptive grant leaves the RR pointer unchanged.
  - Requester 0 cannot preempt itself.
- LCD_ARB_PRIO_EN undefined: pure round-robin with no preemption; requester 0 is treated like any other.

## Structure
- Package lcd_arb_pkg holds:
  - state enum {IDLE, HOLD}
  - LCD_BLANK_LINE constant (16 spaces)
  - a clog2 helper function
- Sub-module lcd_rr_pick: combinational find-first-set starting at pointer+1 with wrap. Inputs are the request vector and pointer; outputs are found and index. It is reused by both the IDLE and HOLD-expiry paths.

## Test plan
All scenarios use NUM_REQ=4, HOLD_CYCLES=8.
- Reset release, then req_valid=4'b0001 held → ack[0] one cycle after; word_line1 = requester 0 text; update pulses; busy high 8 cycles.
- req_valid=4'b1111 held continuously → grants 0,1,2,3,0 exactly 8 cycles apart, one ack each.
- req_valid[2] rises 3 cycles into requester 1's hold → requester 2 is not granted until the hold expires (cycle 8); its text is latched then.
- req_valid[3] pulsed for 2 cycles during HOLD and dropped → no ack[3]; arbiter returns to IDLE; word lines unchanged.
- With LCD_ARB_PRIO_EN: owner=2 at hold count 5, req_valid[0] set → ack[0] next cycle, counter reloads to 7, next RR grant searches from 3. Without the macro: requester 0 waits for expiry.
- in_RST_N pulsed low mid-hold → word lines return to spaces immediately; busy=0; owner=0.

Source files
------------

// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD message arbiter.
// Optional feature macro used by the arbiter: LCD_ARB_PRIO_EN.
package lcd_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam logic [127:0] LCD_BLANK_LINE = {16{8'h20}};

    // Never returns less than 1 so index ports always have a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin find-first-set: first set request bit searching upward from ptr+1 with wrap.
module lcd_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Scan from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing a 16x2 LCD between message sources with a minimum dwell time.
// Define LCD_ARB_PRIO_EN to let requester 0 preempt any other owner during HOLD.
module lcd_msg_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26,
    localparam int IDX_W      = clog2(NUM_REQ)
) (
    input  logic                   in_CLK,
    input  logic                   in_RST_N,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_line1,
    input  logic [NUM_REQ*128-1:0] req_line2,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [127:0]           word_line1,
    output logic [127:0]           word_line2,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy,
    output logic                   update
);

    localparam int               HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HOLD_EFF - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t           state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     rr_ptr;
    logic                 armed;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 grant;
    logic                 move_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   ack_d;
    logic [127:0]         sel_line1, sel_line2;

    lcd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // armed keeps the first edge after reset release free of grants.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        grant     = 1'b0;
        move_ptr  = 1'b0;
        grant_idx = pick_idx;
        case (state)
            IDLE: begin
                if (armed && pick_found) begin
                    grant    = 1'b1;
                    move_ptr = 1'b1;
                    cnt_d    = RELOAD;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
`ifdef LCD_ARB_PRIO_EN
                // Alert preemption leaves the round-robin pointer where it was.
                if (req_valid[0] && owner != '0) begin
                    grant     = 1'b1;
                    grant_idx = '0;
                    cnt_d     = RELOAD;
                end else
`endif
                if (cnt == '0) begin
                    if (pick_found) begin
                        grant    = 1'b1;
                        move_ptr = 1'b1;
                        cnt_d    = RELOAD;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d     = '0;
        sel_line1 = req_line1[127:0];
        sel_line2 = req_line2[127:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                ack_d[i]  = grant;
                sel_line1 = req_line1[i*128 +: 128];
                sel_line2 = req_line2[i*128 +: 128];
            end
        end
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            word_line1 <= LCD_BLANK_LINE;
            word_line2 <= LCD_BLANK_LINE;
            req_ack    <= '0;
            update     <= 1'b0;
            owner      <= '0;
            rr_ptr     <= PTR_INIT;
        end else begin
            req_ack <= ack_d;
            update  <= grant;
            if (grant) begin
                word_line1 <= sel_line1;
                word_line2 <= sel_line2;
                owner      <= grant_idx;
            end
            if (move_ptr) rr_ptr <= grant_idx;
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter with NUM_REQ=4, HOLD_CYCLES=8.
module tb_lcd_msg_arbiter;

    localparam int NUM_REQ = 4;
    localparam int HOLD    = 8;
    localparam logic [127:0] BLANK = {16{8'h20}};

    typedef struct {
        int           cyc;
        int           idx;
        logic [127:0] l1;
        logic [127:0] l2;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*128-1:0] req_line1, req_line2;
    logic [NUM_REQ-1:0]     req_ack;
    logic [127:0]           word_line1, word_line2;
    logic [1:0]             owner;
    logic                   busy, update;

    logic [127:0] l1 [NUM_REQ];
    logic [127:0] l2 [NUM_REQ];
    exp_t         q [$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           c;

    lcd_msg_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (4)
    ) dut (
        .in_CLK     (clk),
        .in_RST_N   (rst_n),
        .req_valid  (req_valid),
        .req_line1  (req_line1),
        .req_line2  (req_line2),
        .req_ack    (req_ack),
        .word_line1 (word_line1),
        .word_line2 (word_line2),
        .owner      (owner),
        .busy       (busy),
        .update     (update)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_line1[i*128 +: 128] = l1[i];
            req_line2[i*128 +: 128] = l2[i];
        end
    end

    function automatic logic [127:0] mk(input logic [7:0] tag, input int i, input int ln);
        return {"REQ", 8'(48 + i), "-L", 8'(48 + ln), "-", tag, "ABCDEFG"};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int cy, input int idx);
        exp_t e;
        e.cyc = cy;
        e.idx = idx;
        e.l1  = l1[idx];
        e.l2  = l2[idx];
        q.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_line1"}, word_line1, BLANK);
        check({tag, "_line2"}, word_line2, BLANK);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_owner"}, 128'(owner), 128'(0));
        check({tag, "_ack"}, 128'(req_ack), 128'(0));
        check({tag, "_update"}, 128'(update), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every ack/update is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (update || req_ack != '0) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_grant: cycle %0d ack %b with no grant expected", cyc, req_ack);
                end else begin
                    e = q.pop_front();
                    check("grant_cycle", 128'(cyc), 128'(e.cyc));
                    check("grant_ack", 128'(req_ack), 128'(4'b0001 << e.idx));
                    check("grant_update", 128'(update), 128'(1));
                    check("grant_owner", 128'(owner), 128'(e.idx));
                    check("grant_line1", word_line1, e.l1);
                    check("grant_line2", word_line2, e.l2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            l1[i] = mk("A", i, 1);
            l2[i] = mk("A", i, 2);
        end
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Sole requester 0, dropped after its ack; busy spans exactly the hold.
        c = cyc;
        push(c + 1, 0);
        req_valid = 4'b0001;
        at_cyc(c + 1);
        req_valid = '0;
        for (int k = 0; k <= HOLD; k++) begin
            check("busy_window", 128'(busy), 128'(k < HOLD));
            @(negedge clk);
        end

        // All requesters held: 0,1,2,3,0 exactly HOLD cycles apart.
        do_reset();
        c = cyc;
        for (int j = 0; j < 5; j++) push(c + 1 + HOLD * j, j % 4);
        req_valid = 4'b1111;
        at_cyc(c + 33);
        req_valid = '0;
        at_cyc(c + 45);
        check("rr_idle_busy", 128'(busy), 128'(0));

        // Requester 2 arrives mid-hold and changes text before its grant.
        do_reset();
        c = cyc;
        push(c + 1, 1);
        req_valid = 4'b0010;
        at_cyc(c + 1);
        req_valid = '0;
        at_cyc(c + 4);
        req_valid[2] = 1'b1;
        at_cyc(c + 5);
        l1[2] = mk("B", 2, 1);
        l2[2] = mk("B", 2, 2);
        push(c + 9, 2);
        at_cyc(c + 9);
        req_valid = '0;
        // Short pulse from requester 3 during the hold must be skipped.
        at_cyc(c + 11);
        req_valid[3] = 1'b1;
        at_cyc(c + 13);
        req_valid[3] = 1'b0;
        at_cyc(c + 18);
        check("skip_busy", 128'(busy), 128'(0));
        check("skip_line1", word_line1, mk("B", 2, 1));
        check("skip_owner", 128'(owner), 128'(2));

        // Requester 0 appears while requester 2 holds at count 5.
        do_reset();
        c = cyc;
        push(c + 1, 2);
        req_valid = 4'b0100;
        at_cyc(c + 1);
        req_valid = '0;
        at_cyc(c + 3);
`ifdef LCD_ARB_PRIO_EN
        push(c + 4, 0);
        push(c + 12, 3);
        push(c + 20, 1);
        req_valid = 4'b1011;
        at_cyc(c + 4);
        req_valid[0] = 1'b0;
        at_cyc(c + 12);
        req_valid[3] = 1'b0;
        at_cyc(c + 20);
        req_valid[1] = 1'b0;
`else
        push(c + 9, 3);
        push(c + 17, 0);
        push(c + 25, 1);
        req_valid = 4'b1011;
        at_cyc(c + 9);
        req_valid[3] = 1'b0;
        at_cyc(c + 17);
        req_valid[0] = 1'b0;
        at_cyc(c + 25);
        req_valid[1] = 1'b0;
`endif
        repeat (10) @(negedge clk);

        // Reset pulse in the middle of a hold.
        do_reset();
        c = cyc;
        push(c + 1, 0);
        req_valid = 4'b0001;
        at_cyc(c + 1);
        req_valid = '0;
        at_cyc(c + 4);
        rst_n = 1'b0;
        #1;
        check_reset_state("midhold_reset");
        at_cyc(c + 6);
        rst_n = 1'b1;
        req_valid = 4'b1000;
        push(c + 8, 3);
        at_cyc(c + 8);
        req_valid = '0;
        at_cyc(c + 20);

        check("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
